// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_arbiter
// Description : Arbitrates one single-port synchronous framebuffer RAM between
//               the VGA scanout line fetcher (fixed-length read bursts, strict
//               priority) and a valid/ready single-beat pixel writer.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 12,
    parameter int BURST  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // scanout fetcher
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_ack_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              rd_done_o,
    // pixel writer
    input  logic              wr_valid_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    // framebuffer RAM
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam int                c_BEAT_W    = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [c_BEAT_W-1:0] r_beat;
    logic                r_ack;
    logic                r_done;
    logic                r_valid;

    logic                w_wr_ready;
    logic                w_wr_fire;
    logic                w_rd_fire;

    // RAM strobes are decoded from the current state; reset masks any access
    // in the same cycle so a handshake coinciding with reset never commits.
    always_comb begin
        w_wr_ready  = (r_state == S_IDLE) && !rd_req_i;
        w_wr_fire   = w_wr_ready && wr_valid_i && !rst_i;
        w_rd_fire   = (r_state == S_BURST) && !rst_i;
        ram_en_o    = w_wr_fire || w_rd_fire;
        ram_we_o    = w_wr_fire;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (w_rd_fire) begin
            ram_addr_o = r_base + ADDR_W'(r_beat);
        end else if (w_wr_fire) begin
            ram_addr_o  = wr_addr_i;
            ram_wdata_o = wr_data_i;
        end
    end

    // Burst sequencer: accept a fetch in IDLE, walk BURST addresses, then one
    // drain cycle while the last read beat returns.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_beat  <= '0;
            r_ack   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ack  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rd_req_i) begin
                        r_base  <= rd_addr_i;
                        r_beat  <= '0;
                        r_ack   <= 1'b1;
                        r_state <= S_BURST;
                    end
                end
                S_BURST: begin
                    r_beat <= r_beat + 1'b1;
                    if (r_beat == c_LAST_BEAT) begin
                        r_done  <= 1'b1;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read-return valid tracks each read strobe by one cycle, matching the
    // RAM's own output register; reset drops any beat still in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= ram_en_o && !ram_we_o;
        end
    end

    // The RAM output register is the data pipeline stage, so the pixel is
    // forwarded only while the registered valid is high and is zero otherwise.
    assign rd_data_o  = r_valid ? ram_rdata_i : '0;
    assign rd_valid_o = r_valid;
    assign rd_ack_o   = r_ack;
    assign rd_done_o  = r_done;
    assign wr_ready_o = w_wr_ready;

endmodule
`default_nettype wire
